qam16_carrier_mod_tx: RTL and testbench



---
 rtl/qam16_carrier_mod_tx.sv | 152 +++++++++++++++
 tb/tb_qam16_carrier_mod_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_carrier_mod_tx.sv
// QAM-16 transmit modulator: maps a 4-bit Gray-coded symbol to I/Q levels
// and emits 16 passband samples per symbol, s[k] = I*cos(2*pi*k/16) - Q*sin(2*pi*k/16).
module qam16_carrier_mod_tx #(
    parameter int unsigned WIDTH_SYM = 16,
    parameter int unsigned AMP_UNIT  = 2048
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  sym_in,
    input  logic                        sym_valid,
    output logic                        sym_ready,
    output logic signed [WIDTH_SYM-1:0] data_out,
    output logic                        data_valid,
    output logic [3:0]                  sample_idx,
    output logic                        sym_start
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH_SYM-1:0] Amp1 = WIDTH_SYM'(AMP_UNIT);
    localparam logic [WIDTH_SYM-1:0] Amp3 = WIDTH_SYM'(3 * AMP_UNIT);
    // Symmetric saturation bounds: +/-(2^(W-1) - 1)
    localparam logic signed [WIDTH_SYM:0] SatMax = {2'b00, {(WIDTH_SYM-1){1'b1}}};
    localparam logic signed [WIDTH_SYM:0] SatMin = -SatMax;

    state_e                     state_q;
    logic [3:0]                 phase_q;
    logic signed [2:0]          i_lvl_q;
    logic signed [2:0]          q_lvl_q;
    logic signed [WIDTH_SYM:0]  i_term;
    logic signed [WIDTH_SYM:0]  q_term;
    logic signed [WIDTH_SYM:0]  sum;
    logic signed [WIDTH_SYM-1:0] sample;

    // Gray map: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
    function automatic logic signed [2:0] gray_level(input logic [1:0] b);
        logic signed [2:0] lvl;
        unique case (b)
            2'b00:   lvl = -3'sd3;
            2'b01:   lvl = -3'sd1;
            2'b11:   lvl = 3'sd1;
            default: lvl = 3'sd3;
        endcase
        return lvl;
    endfunction

    // Carrier magnitude selector: C4 at k=0/8, C0 at k=4/12, mirrored between
    function automatic logic [2:0] mag_sel(input logic [3:0] k);
        logic [2:0] d;
        d = k[2] ? (3'd0 - k[2:0]) : k[2:0];
        return 3'd4 - d;
    endfunction

    // Shift-add carrier constants, each term truncated on its own
    function automatic logic [WIDTH_SYM-1:0] carrier_mag(input logic [2:0] sel,
                                                          input logic [WIDTH_SYM-1:0] m);
        logic [WIDTH_SYM-1:0] p;
        unique case (sel)
            3'd4:    p = m;
            3'd3:    p = (m >> 1) + (m >> 2) + (m >> 3) + (m >> 5) + (m >> 6) + (m >> 9);
            3'd2:    p = (m >> 1) + (m >> 3) + (m >> 4) + (m >> 6) + (m >> 8);
            3'd1:    p = (m >> 2) + (m >> 3) + (m >> 8) + (m >> 9) + (m >> 10) + (m >> 11)
                         + (m >> 12);
            default: p = '0;
        endcase
        return p;
    endfunction

    // Signed product level * cos(2*pi*k/16); zero carrier yields exact 0
    function automatic logic signed [WIDTH_SYM:0] term(input logic signed [2:0] lvl,
                                                       input logic [3:0] k);
        logic [WIDTH_SYM-1:0] m;
        logic [WIDTH_SYM-1:0] p;
        logic                 neg;
        logic signed [WIDTH_SYM:0] mag;
        if (lvl == 3'sd0) begin
            m = '0;
        end else if ((lvl == 3'sd3) || (lvl == -3'sd3)) begin
            m = Amp3;
        end else begin
            m = Amp1;
        end
        p   = carrier_mag(mag_sel(k), m);
        neg = lvl[2] ^ ((k >= 4'd5) && (k <= 4'd11));
        mag = $signed({1'b0, p});
        if ((k == 4'd4) || (k == 4'd12)) begin
            return '0;
        end
        return neg ? -mag : mag;
    endfunction

    assign sym_ready = (state_q == StIdle) || (phase_q == 4'd15);

    // Sample for the current phase; sin(k) reuses the cosine table at k-4
    always_comb begin
        i_term = term(i_lvl_q, phase_q);
        q_term = term(q_lvl_q, phase_q - 4'd4);
        sum    = i_term - q_term;
        if (sum > SatMax) begin
            sample = SatMax[WIDTH_SYM-1:0];
        end else if (sum < SatMin) begin
            sample = SatMin[WIDTH_SYM-1:0];
        end else begin
            sample = sum[WIDTH_SYM-1:0];
        end
    end

    // Symbol acceptance, phase sequencing and registered sample output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= 4'd0;
            i_lvl_q    <= '0;
            q_lvl_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sample_idx <= 4'd0;
            sym_start  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    data_out   <= '0;
                    data_valid <= 1'b0;
                    sym_start  <= 1'b0;
                    if (sym_valid) begin
                        i_lvl_q <= gray_level(sym_in[3:2]);
                        q_lvl_q <= gray_level(sym_in[1:0]);
                        phase_q <= 4'd0;
                        state_q <= StRun;
                    end
                end
                default: begin
                    data_out   <= sample;
                    data_valid <= 1'b1;
                    sample_idx <= phase_q;
                    sym_start  <= (phase_q == 4'd0);
                    // Wraps 15 -> 0, giving a seamless start for a chained symbol
                    phase_q    <= phase_q + 4'd1;
                    if (phase_q == 4'd15) begin
                        if (sym_valid) begin
                            i_lvl_q <= gray_level(sym_in[3:2]);
                            q_lvl_q <= gray_level(sym_in[1:0]);
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qam16_carrier_mod_tx.sv
// Self-checking bench for qam16_carrier_mod_tx against a queue-based reference model.
module tb_qam16_carrier_mod_tx;

    localparam int W   = 16;
    localparam int AMP = 2048;

    logic                clk;
    logic                rst_n;
    logic [3:0]          sym_in;
    logic                sym_valid;
    logic                sym_ready;
    logic signed [W-1:0] data_out;
    logic                data_valid;
    logic [3:0]          sample_idx;
    logic                sym_start;

    qam16_carrier_mod_tx #(.WIDTH_SYM(W), .AMP_UNIT(AMP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sample_idx (sample_idx),
        .sym_start  (sym_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        int idx;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cap[16];
    bit   initialized = 0;
    bit   last_acc;

    int level_tab[4] = '{-3, -1, 3, 1};
    int mag_tab[16]  = '{4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3};
    int sign_tab[16] = '{1, 1, 1, 1, 0, -1, -1, -1, -1, -1, -1, -1, 0, 1, 1, 1};

    function automatic int cmag(int m, int c);
        case (c)
            4: return m;
            3: return (m >> 1) + (m >> 2) + (m >> 3) + (m >> 5) + (m >> 6) + (m >> 9);
            2: return (m >> 1) + (m >> 3) + (m >> 4) + (m >> 6) + (m >> 8);
            1: return (m >> 2) + (m >> 3) + (m >> 8) + (m >> 9) + (m >> 10) + (m >> 11)
                      + (m >> 12);
            default: return 0;
        endcase
    endfunction

    // level * cos(2*pi*k/16) using the sign/magnitude tables
    function automatic int cos_term(int lvl, int k);
        int m;
        int s;
        m = (lvl < 0 ? -lvl : lvl) * AMP;
        s = (lvl < 0 ? -1 : 1) * sign_tab[k];
        return s * cmag(m, mag_tab[k]);
    endfunction

    function automatic int ref_sample(logic [3:0] sym, int k);
        int i_l;
        int q_l;
        int v;
        int lim;
        i_l = level_tab[sym[3:2]];
        q_l = level_tab[sym[1:0]];
        v   = cos_term(i_l, k) - cos_term(q_l, (k + 12) % 16);
        lim = (1 << (W - 1)) - 1;
        if (v > lim) v = lim;
        if (v < -lim) v = -lim;
        return v;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: check sym_ready before the edge, outputs #1 after it
    task automatic tick();
        bit   exp_ready;
        bit   acc;
        logic [3:0] s;
        exp_t e;
        exp_ready = (q.size() <= 1);
        if (rst_n && initialized) check("sym_ready", sym_ready, exp_ready);
        acc      = rst_n && sym_valid && exp_ready;
        s        = sym_in;
        last_acc = acc;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            initialized = 1;
            check("rst_valid", data_valid, 0);
            check("rst_data", data_out, 0);
            check("rst_idx", sample_idx, 0);
            check("rst_start", sym_start, 0);
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                check("valid", data_valid, 1);
                check("data", data_out, e.val);
                check("idx", sample_idx, e.idx);
                check("start", sym_start, (e.idx == 0) ? 1 : 0);
                cap[e.idx] = data_out;
            end else begin
                check("idle_valid", data_valid, 0);
                check("idle_data", data_out, 0);
                check("idle_start", sym_start, 0);
            end
            if (acc) begin
                for (int k = 0; k < 16; k++) begin
                    e.val = ref_sample(s, k);
                    e.idx = k;
                    q.push_back(e);
                end
            end
        end
    endtask

    // Present a symbol until accepted (bounded), then drop sym_valid
    task automatic send(input logic [3:0] s);
        int n;
        sym_in    = s;
        sym_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) check("accept_timeout", 0, 1);
        sym_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
    endtask

    initial begin
        int vcount;
        int run;
        int starts;
        logic [3:0] s;

        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym_in    = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;

        // Single symbol I=+3, Q=-3
        send(4'b1000);
        drain();
        check("s1000_0", cap[0], 6144);
        check("s1000_2", cap[2], 8688);
        check("s1000_4", cap[4], 6144);
        check("s1000_8", cap[8], -6144);
        check("s1000_12", cap[12], -6144);

        // I=-1, Q=-1
        send(4'b0101);
        drain();
        check("s0101_0", cap[0], -2048);
        check("s0101_1", cap[1], -1109);
        check("s0101_4", cap[4], 2048);

        // Back-to-back with sym_valid held high
        sym_in    = 4'b1010;
        sym_valid = 1'b1;
        tick();
        sym_in = 4'b0000;
        vcount = 0;
        run    = 0;
        starts = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (last_acc) sym_valid = 1'b0;
            if (data_valid) begin
                run++;
                if (run > vcount) vcount = run;
            end else begin
                run = 0;
            end
            if (sym_start) starts++;
        end
        check("b2b_run", vcount, 32);
        check("b2b_starts", starts, 2);

        // Stall: gap of idle cycles between symbols
        send(4'b1111);
        repeat (16) tick();
        repeat (5) tick();
        send(4'b0110);
        check("stall_valid", data_valid, 0);
        tick();
        check("stall_first_valid", data_valid, 1);
        check("stall_first_idx", sample_idx, 0);
        drain();

        // Ignored requests while busy
        send(4'b1101);
        sym_valid = 1'b1;
        repeat (14) begin
            sym_in = 4'($urandom_range(0, 15));
            tick();
        end
        sym_valid = 1'b0;
        drain();
        for (int k = 0; k < 16; k++) check("ignored_req", cap[k], ref_sample(4'b1101, k));

        // Reset mid-symbol
        send(4'b0011);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready", sym_ready, 1);
        send(4'b1001);
        tick();
        check("restart_idx", sample_idx, 0);
        check("restart_start", sym_start, 1);
        drain();

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            s         = 4'($urandom_range(0, 15));
            sym_in    = s;
            sym_valid = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n     = 1'b1;
        sym_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
